// File: rtl/cpu_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_cycle_controller
//  Brief    : Multi-cycle instruction sequencer for the MIPS core. Steps each
//             instruction through FETCH, EXEC, optional MULDIV / MEM wait
//             states and WB. Drives the bus strobes, IR load, register-file
//             write and PC update, and tracks the branch delay slot.
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_cycle_controller #(
    parameter int WAIT_TIMEOUT = 0,   // consecutive stall cycles allowed per access; 0 = unbounded
    parameter int CNT_W        = 8    // wait counter width
) (
    input  logic clk,
    input  logic reset,
    input  logic waitrequest,
    input  logic reg_wr_en,
    input  logic mem_wr_en,
    input  logic is_load,
    input  logic is_muldiv,
    input  logic pc_branch,
    input  logic branch_taken,
    input  logic pc_jump,
    input  logic target_is_zero,
    input  logic muldiv_done,
    output logic mem_read,
    output logic mem_write,
    output logic addr_sel,
    output logic ir_load,
    output logic muldiv_start,
    output logic reg_write,
    output logic pc_wr_en,
    output logic pc_sel,
    output logic target_latch_en,
    output logic active,
    output logic fault
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] c_ST_FETCH  = 3'd0;
    localparam logic [2:0] c_ST_EXEC   = 3'd1;
    localparam logic [2:0] c_ST_MULDIV = 3'd2;
    localparam logic [2:0] c_ST_MEM    = 3'd3;
    localparam logic [2:0] c_ST_WB     = 3'd4;
    localparam logic [2:0] c_ST_HALTED = 3'd5;

    // Counter value seen during the last permitted stall cycle. The access
    // faults when waitrequest is still high in the cycle that would bring the
    // count up to WAIT_TIMEOUT, so exactly WAIT_TIMEOUT stall cycles occur
    // before the sequencer drops into HALTED.
    localparam logic [CNT_W-1:0] c_TIMEOUT_LAST =
        (WAIT_TIMEOUT == 0) ? '0 : CNT_W'(WAIT_TIMEOUT - 1);

    // The counter must be able to represent the timeout value.
    generate
        if (WAIT_TIMEOUT < 0 || WAIT_TIMEOUT >= (2 ** CNT_W)) begin : g_param_check
            $error("cpu_cycle_controller: WAIT_TIMEOUT out of range for CNT_W");
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic             r_delay_pending;
    logic             w_delay_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;
    logic [CNT_W-1:0] w_wait_cnt_inc;
    logic             r_fault;
    logic             w_fault_nxt;
    logic             w_timeout;
    logic             w_redirect;

    // Saturating increment so a long unbounded stall never wraps the counter.
    assign w_wait_cnt_inc = (r_wait_cnt == {CNT_W{1'b1}}) ? r_wait_cnt
                                                          : r_wait_cnt + CNT_W'(1);

    // Stall budget exhausted while the bus is still stalling.
    assign w_timeout = (WAIT_TIMEOUT != 0) && waitrequest &&
                       (r_wait_cnt >= c_TIMEOUT_LAST);

    // Instruction in WB redirects control flow after its delay slot.
    assign w_redirect = (pc_branch & branch_taken) | pc_jump;

    // ------------------------------------------------------------------------
    // State register: sequencer state, delay-slot flag, wait counter, fault
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_ST_FETCH;
            r_delay_pending <= 1'b0;
            r_wait_cnt      <= '0;
            r_fault         <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_delay_pending <= w_delay_nxt;
            r_wait_cnt      <= w_wait_cnt_nxt;
            r_fault         <= w_fault_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: transitions, stall counting and delay-slot tracking
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt    = r_state;
        w_delay_nxt    = r_delay_pending;
        w_wait_cnt_nxt = r_wait_cnt;
        w_fault_nxt    = r_fault;

        case (r_state)
            // Both bus states share the same stall / timeout handling; only
            // the state reached on completion differs.
            c_ST_FETCH, c_ST_MEM: begin
                if (waitrequest) begin
                    w_wait_cnt_nxt = w_wait_cnt_inc;
                    if (w_timeout) begin
                        w_state_nxt = c_ST_HALTED;
                        w_fault_nxt = 1'b1;
                    end
                end else begin
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = (r_state == c_ST_FETCH) ? c_ST_EXEC : c_ST_WB;
                end
            end

            c_ST_EXEC: begin
                if (is_muldiv) begin
                    w_state_nxt = c_ST_MULDIV;
                end else if (is_load || mem_wr_en) begin
                    w_state_nxt = c_ST_MEM;
                end else begin
                    w_state_nxt = c_ST_WB;
                end
            end

            // The start pulse is issued in EXEC, so a done seen in that same
            // cycle is never sampled here.
            c_ST_MULDIV: begin
                if (muldiv_done) begin
                    w_state_nxt = c_ST_WB;
                end
            end

            c_ST_WB: begin
                // A redirect in the delay slot both consumes the old target
                // and latches a new one, so the flag simply stays set.
                if (w_redirect) begin
                    w_delay_nxt = 1'b1;
                end else if (r_delay_pending) begin
                    w_delay_nxt = 1'b0;
                end
                // A pending jump to address 0 is the halt convention.
                if (r_delay_pending && target_is_zero) begin
                    w_state_nxt = c_ST_HALTED;
                end else begin
                    w_state_nxt = c_ST_FETCH;
                end
            end

            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end

            default: begin
                w_state_nxt = c_ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode: Moore outputs of the state, gated by decode inputs
    // ------------------------------------------------------------------------
    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        addr_sel        = 1'b0;
        ir_load         = 1'b0;
        muldiv_start    = 1'b0;
        reg_write       = 1'b0;
        pc_wr_en        = 1'b0;
        pc_sel          = 1'b0;
        target_latch_en = 1'b0;
        active          = 1'b1;

        case (r_state)
            c_ST_FETCH: begin
                mem_read = 1'b1;
                addr_sel = 1'b0;
                ir_load  = ~waitrequest;
            end

            c_ST_EXEC: begin
                muldiv_start = is_muldiv;
            end

            c_ST_MULDIV: begin
                // No strobes while the unit computes.
            end

            c_ST_MEM: begin
                mem_read  = is_load;
                mem_write = mem_wr_en;
                addr_sel  = 1'b1;
            end

            c_ST_WB: begin
                reg_write       = reg_wr_en;
                pc_wr_en        = 1'b1;
                pc_sel          = r_delay_pending;
                target_latch_en = w_redirect;
            end

            c_ST_HALTED: begin
                active = 1'b0;
            end

            default: begin
                active = 1'b1;
            end
        endcase
    end

    assign fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_cpu_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cpu_cycle_controller
//  Brief    : Directed, table-driven bench for cpu_cycle_controller. Two
//             instances share stimulus: one unbounded, one with a 4-cycle
//             bus timeout.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_cycle_controller;

    // Input vector bit positions
    localparam logic [10:0] I_RST  = 11'b100_0000_0000;
    localparam logic [10:0] I_WAIT = 11'b010_0000_0000;
    localparam logic [10:0] I_RW   = 11'b001_0000_0000;
    localparam logic [10:0] I_MW   = 11'b000_1000_0000;
    localparam logic [10:0] I_LD   = 11'b000_0100_0000;
    localparam logic [10:0] I_MD   = 11'b000_0010_0000;
    localparam logic [10:0] I_BR   = 11'b000_0001_0000;
    localparam logic [10:0] I_BT   = 11'b000_0000_1000;
    localparam logic [10:0] I_JP   = 11'b000_0000_0100;
    localparam logic [10:0] I_TZ   = 11'b000_0000_0010;
    localparam logic [10:0] I_DONE = 11'b000_0000_0001;

    // Output vector: {mem_read, mem_write, addr_sel, ir_load, muldiv_start,
    //                 reg_write, pc_wr_en, pc_sel, target_latch_en, active, fault}
    localparam logic [10:0] E_FETCH  = 11'b100_1000_0010;
    localparam logic [10:0] E_FSTALL = 11'b100_0000_0010;
    localparam logic [10:0] E_IDLE   = 11'b000_0000_0010;
    localparam logic [10:0] E_MDST   = 11'b000_0100_0010;
    localparam logic [10:0] E_MEMRD  = 11'b101_0000_0010;
    localparam logic [10:0] E_MEMWR  = 11'b011_0000_0010;
    localparam logic [10:0] E_WB     = 11'b000_0001_0010;
    localparam logic [10:0] E_RW     = 11'b000_0010_0000;
    localparam logic [10:0] E_PS     = 11'b000_0000_1000;
    localparam logic [10:0] E_TL     = 11'b000_0000_0100;
    localparam logic [10:0] E_HALT   = 11'b000_0000_0000;
    localparam logic [10:0] E_HALTF  = 11'b000_0000_0001;

    typedef struct {
        logic [10:0] in;
        logic [10:0] exp;
    } vec_t;

    vec_t vecs[$];

    logic clk = 1'b0;
    logic reset, waitrequest, reg_wr_en, mem_wr_en, is_load, is_muldiv;
    logic pc_branch, branch_taken, pc_jump, target_is_zero, muldiv_done;
    wire [10:0] out0;
    wire [10:0] out4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_cycle_controller u_dut (
        .clk(clk), .reset(reset), .waitrequest(waitrequest),
        .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en), .is_load(is_load),
        .is_muldiv(is_muldiv), .pc_branch(pc_branch), .branch_taken(branch_taken),
        .pc_jump(pc_jump), .target_is_zero(target_is_zero), .muldiv_done(muldiv_done),
        .mem_read(out0[10]), .mem_write(out0[9]), .addr_sel(out0[8]),
        .ir_load(out0[7]), .muldiv_start(out0[6]), .reg_write(out0[5]),
        .pc_wr_en(out0[4]), .pc_sel(out0[3]), .target_latch_en(out0[2]),
        .active(out0[1]), .fault(out0[0])
    );

    cpu_cycle_controller #(.WAIT_TIMEOUT(4), .CNT_W(8)) u_dut_to (
        .clk(clk), .reset(reset), .waitrequest(waitrequest),
        .reg_wr_en(reg_wr_en), .mem_wr_en(mem_wr_en), .is_load(is_load),
        .is_muldiv(is_muldiv), .pc_branch(pc_branch), .branch_taken(branch_taken),
        .pc_jump(pc_jump), .target_is_zero(target_is_zero), .muldiv_done(muldiv_done),
        .mem_read(out4[10]), .mem_write(out4[9]), .addr_sel(out4[8]),
        .ir_load(out4[7]), .muldiv_start(out4[6]), .reg_write(out4[5]),
        .pc_wr_en(out4[4]), .pc_sel(out4[3]), .target_latch_en(out4[2]),
        .active(out4[1]), .fault(out4[0])
    );

    task automatic drive(input logic [10:0] in);
        {reset, waitrequest, reg_wr_en, mem_wr_en, is_load, is_muldiv,
         pc_branch, branch_taken, pc_jump, target_is_zero, muldiv_done} = in;
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [10:0] act, input logic [10:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %b, expected %b", nm, idx, act, exp);
        end
    endtask

    // Drive inputs for one cycle, compare both instances at the falling edge.
    task automatic cyc(input string nm, input int idx, input logic [10:0] in,
                       input logic [10:0] exp0, input logic [10:0] exp4);
        drive(in);
        @(negedge clk);
        chk({nm, "_u0"}, idx, out0, exp0);
        chk({nm, "_u4"}, idx, out4, exp4);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(I_RST);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [10:0] in, input logic [10:0] exp);
        vec_t v;
        v.in  = in;
        v.exp = exp;
        vecs.push_back(v);
    endtask

    // Three-cycle instruction: FETCH, EXEC, WB
    task automatic instr3(input logic [10:0] in, input logic [10:0] wb_exp);
        add(in, E_FETCH);
        add(in, E_IDLE);
        add(in, wb_exp);
    endtask

    initial begin
        // ---------------- vector table ----------------
        instr3(I_RW, E_WB | E_RW);                         // ADDU
        add(I_LD | I_RW, E_FETCH);                         // LW, 2 MEM stalls
        add(I_LD | I_RW, E_IDLE);
        add(I_LD | I_RW | I_WAIT, E_MEMRD);
        add(I_LD | I_RW | I_WAIT, E_MEMRD);
        add(I_LD | I_RW, E_MEMRD);
        add(I_LD | I_RW, E_WB | E_RW);
        add(I_MW | I_WAIT, E_FSTALL);                      // SW, 1 FETCH stall
        add(I_MW, E_FETCH);
        add(I_MW, E_IDLE);
        add(I_MW, E_MEMWR);
        add(I_MW, E_WB);
        instr3(I_BR | I_BT, E_WB | E_TL);                  // BEQ taken
        instr3(I_RW, E_WB | E_RW | E_PS);                  // delay slot consumes target
        instr3(I_RW, E_WB | E_RW);                         // pending cleared
        instr3(I_BR, E_WB);                                // BEQ not taken
        instr3(I_BT | I_RW, E_WB | E_RW);                  // taken flag without branch
        instr3(I_TZ | I_RW, E_WB | E_RW);                  // zero target, nothing pending
        instr3(I_JP, E_WB | E_TL);                         // J
        instr3(I_BR | I_BT, E_WB | E_PS | E_TL);           // branch in delay slot
        instr3(I_RW, E_WB | E_RW | E_PS);                  // consumes second target
        instr3(I_RW, E_WB | E_RW);
        add(I_MD, E_FETCH);                                // MULT, done 5 after start
        add(I_MD | I_DONE, E_MDST);                        // early done ignored
        for (int i = 0; i < 4; i++) add(I_MD, E_IDLE);
        add(I_MD | I_DONE, E_IDLE);
        add(I_MD, E_WB);
        instr3(I_JP | I_TZ, E_WB | E_TL);                  // JR to 0
        instr3(I_TZ, E_WB | E_PS);                         // NOP slot -> halt
        for (int i = 0; i < 10; i++)
            add(I_WAIT | I_RW | I_JP | I_TZ | I_DONE | I_MD | I_MW, E_HALT);

        // ---------------- reset state ----------------
        drive(I_RST | I_WAIT);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_u0", 0, out0, E_FSTALL);
        chk("reset_u4", 0, out4, E_FSTALL);
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        for (int i = 0; i < vecs.size(); i++)
            cyc("vec", i, vecs[i].in, vecs[i].exp, vecs[i].exp);

        // ---------------- reset mid-MEM ----------------
        do_reset();
        cyc("rmem", 0, I_MW, E_FETCH, E_FETCH);
        cyc("rmem", 1, I_MW, E_IDLE, E_IDLE);
        cyc("rmem", 2, I_MW | I_WAIT, E_MEMWR, E_MEMWR);
        cyc("rmem", 3, I_RST | I_MW | I_WAIT, E_MEMWR, E_MEMWR);
        cyc("rmem", 4, I_MW | I_WAIT, E_FSTALL, E_FSTALL);

        // ---------------- FETCH timeout ----------------
        do_reset();
        for (int k = 0; k < 4; k++)
            cyc("to_fetch", k, I_WAIT, E_FSTALL, E_FSTALL);
        cyc("to_fetch", 4, I_WAIT, E_FSTALL, E_HALTF);
        drive(I_WAIT);
        repeat (300) @(posedge clk);
        #1;
        cyc("to_long", 0, I_WAIT, E_FSTALL, E_HALTF);
        cyc("to_release", 0, 11'b0, E_FETCH, E_HALTF);
        do_reset();
        cyc("to_clear", 0, I_WAIT, E_FSTALL, E_FSTALL);

        // ---------------- MEM timeout (counter cleared on FETCH exit) ------
        cyc("to_mem", 0, I_LD, E_FETCH, E_FETCH);
        cyc("to_mem", 1, I_LD, E_IDLE, E_IDLE);
        for (int k = 0; k < 4; k++)
            cyc("to_mem", 2 + k, I_LD | I_WAIT, E_MEMRD, E_MEMRD);
        cyc("to_mem", 6, I_LD | I_WAIT, E_MEMRD, E_HALTF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cpu_cycle_controller.md
Name: cpu_cycle_controller

Overview:
Multi-cycle sequencer for the MIPS core. It steps each instruction through FETCH, EXEC, optional MULDIV/MEM wait states, and WB. It drives the bus read/write strobes, instruction-register load, register-file write, and PC update, including branch-delay-slot handling. It consumes the control bits produced by instruction decode and stalls on bus waitrequest and on the multi-cycle multiply/divide unit.

Parameters:
WAIT_TIMEOUT, 0, max consecutive waitrequest cycles in one bus access before fault; 0 = unbounded
CNT_W, 8, width of the wait counter; WAIT_TIMEOUT must be < 2^CNT_W

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  synchronous, active-high
waitrequest  input  1  bus stall for the current read/write
reg_wr_en  input  1  decoded: instruction writes the register file
mem_wr_en  input  1  decoded: store instruction
is_load  input  1  decoded: load instruction
is_muldiv  input  1  decoded: MULT/MULTU/DIV/DIVU
pc_branch  input  1  decoded: conditional branch
branch_taken  input  1  ALU branch condition, valid in EXEC and WB
pc_jump  input  1  decoded: J/JAL/JR/JALR
target_is_zero  input  1  latched branch/jump target equals 0
muldiv_done  input  1  mult/div unit result ready
mem_read  output  1  bus read strobe
mem_write  output  1  bus write strobe
addr_sel  output  1  0 = PC drives bus address, 1 = ALU result drives it
ir_load  output  1  load instruction register
muldiv_start  output  1  one-cycle start pulse to mult/div unit
reg_write  output  1  register-file write enable
pc_wr_en  output  1  PC update enable
pc_sel  output  1  0 = PC+4, 1 = latched target
target_latch_en  output  1  capture branch/jump target
active  output  1  CPU running; 0 once halted
fault  output  1  sticky bus-timeout flag

Behaviour:
- States: FETCH, EXEC, MULDIV, MEM, WB, HALTED. Outputs are Moore decodes of state, gated by the listed inputs.
- Reset: state=FETCH, delay_pending=0, wait_cnt=0, active=1, fault=0. Every strobe is 0 except the FETCH decodes (mem_read=1, addr_sel=0). Reset overrides all states, including mid-bus-access.
- FETCH: mem_read=1, addr_sel=0.
  - waitrequest=1: stay in FETCH, wait_cnt++.
  - Otherwise: ir_load=1, go to EXEC, wait_cnt←0.
- EXEC:
  - is_muldiv: muldiv_start=1 for exactly this cycle, then MULDIV.
  - is_load|mem_wr_en: MEM.
  - Else: WB.
  - Single cycle; no strobes other than muldiv_start.
- MULDIV: hold until muldiv_done=1, then WB. muldiv_done asserted in the same cycle as the start pulse is ignored.
- MEM: mem_read=is_load, mem_write=mem_wr_en, addr_sel=1. Stall on waitrequest as in FETCH. When waitrequest=0, go to WB and clear wait_cnt.
- WB (one cycle): reg_write=reg_wr_en, pc_wr_en=1, pc_sel=delay_pending.
  - If (pc_branch&branch_taken)|pc_jump: target_latch_en=1, delay_pending←1.
  - Else if delay_pending: delay_pending←0.
  - If delay_pending=1 and target_is_zero=1: go to HALTED. Otherwise go to FETCH.
- Branch in a delay slot: the old target is consumed (pc_sel=1 this cycle), the new target is latched, and delay_pending stays 1.
- HALTED: all strobes 0, active=0. Only reset exits.
- Timeout (WAIT_TIMEOUT≠0): in FETCH/MEM, when wait_cnt reaches WAIT_TIMEOUT with waitrequest still 1, the next state is HALTED with fault←1 and the strobes drop. wait_cnt saturates and does not wrap.
- Strobes stay stable throughout a stalled access (bus protocol requirement).
- Latency with no waits: ALU/branch/jump = 3 cycles; load/store = 4 cycles; mult/div = 4 + unit latency.

Test Plan:
- ADDU, no waits → FETCH,EXEC,WB. ir_load in cycle 1; reg_write=1 and pc_wr_en=1 with pc_sel=0 in cycle 3; next FETCH in cycle 4.
- LW with waitrequest held 2 cycles in MEM → mem_read=1, addr_sel=1 stable for 3 cycles; reg_write in the following WB; total 6 cycles.
- BEQ taken, then ADDU → BEQ WB: target_latch_en=1, pc_sel=0. ADDU WB: pc_sel=1, delay_pending cleared.
- JR to 0, then NOP delay slot → NOP WB with target_is_zero=1 → HALTED; active=0 next cycle; strobes stay 0 for 10 further cycles.
- MULT with muldiv_done 5 cycles after start → exactly one muldiv_start pulse; WB with reg_write=0; no bus strobes in MULDIV.
- WAIT_TIMEOUT=4, waitrequest stuck high in FETCH → fault=1, HALTED after 4 stall cycles. Reset asserted mid-MEM → next cycle FETCH, mem_write=0, active=1.
